// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID checker that also arbitrates CPU reads onto the sysid Avalon-MM slave.
// Reads ID (addr 0) and build timestamp (addr 1) after reset or on start, then forwards CPU reads.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1361531825,
  parameter int unsigned READ_LATENCY       = 0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        cpu_address,
  input  logic        cpu_read,
  output logic [31:0] cpu_readdata,
  output logic        cpu_waitrequest,
  output logic        slv_address,
  output logic        slv_read,
  input  logic [31:0] slv_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  typedef enum logic [2:0] {
    IDLE,
    CHK_ID,
    CHK_TS,
    CPU_RD,
    CPU_ACK
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic       sample;

  assign sample = (cnt == LAT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= CHK_ID;
      cnt          <= '0;
      done         <= 1'b0;
      id_ok        <= 1'b0;
      ts_ok        <= 1'b0;
      captured_id  <= '0;
      captured_ts  <= '0;
      cpu_readdata <= '0;
      slv_address  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= CHK_ID;
            slv_address <= 1'b0;
          end else if (cpu_read) begin
            state       <= CPU_RD;
            slv_address <= cpu_address;
          end
        end
        CHK_ID: begin
          if (sample) begin
            cnt         <= '0;
            captured_id <= slv_readdata;
            id_ok       <= (slv_readdata == EXPECTED_ID);
            slv_address <= 1'b1;
            state       <= CHK_TS;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        CHK_TS: begin
          if (sample) begin
            cnt         <= '0;
            captured_ts <= slv_readdata;
            ts_ok       <= (slv_readdata == EXPECTED_TIMESTAMP);
            done        <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        CPU_RD: begin
          if (sample) begin
            cnt          <= '0;
            cpu_readdata <= slv_readdata;
            state        <= CPU_ACK;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        CPU_ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The reset state is CHK_ID, so the strobe is gated by reset to stay low while reset is held.
  assign slv_read        = reset_n && ((state == CHK_ID) || (state == CHK_TS) || (state == CPU_RD));
  assign busy            = (state == CHK_ID) || (state == CHK_TS);
  assign cpu_waitrequest = (state != CPU_ACK);

endmodule

// File: doc/sysid_boot_checker.md
Name: sysid_boot_checker

Overview:
- Sequencer and arbiter in front of the system-ID Avalon-MM slave: ID word at address 0, build timestamp at address 1.
- After reset, or on request, it reads both words, compares them with the expected values, and reports match/mismatch to boot logic and LED/status registers.
- When no check is running, it forwards CPU reads to the same slave, so the slave has one master port.

Parameters:
- EXPECTED_ID, 32'h00000000, value the slave must return at address 0.
- EXPECTED_TIMESTAMP, 32'd1361531825, value the slave must return at address 1.
- READ_LATENCY, 0, number of cycles after the first slv_read cycle at which slv_readdata is sampled; legal range 0..7.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse requesting a re-check.
- cpu_address  in  1  CPU read address.
- cpu_read  in  1  CPU read request; held until waitrequest is low.
- cpu_readdata  out  32  CPU read data; valid while cpu_waitrequest is low.
- cpu_waitrequest  out  1  Avalon waitrequest to the CPU.
- slv_address  out  1  address to the sysid slave.
- slv_read  out  1  read strobe to the sysid slave.
- slv_readdata  in  32  sysid slave read data.
- busy  out  1  high while a check is in progress.
- done  out  1  a check has completed since reset; sticky.
- id_ok  out  1  captured ID equals EXPECTED_ID.
- ts_ok  out  1  captured timestamp equals EXPECTED_TIMESTAMP.
- captured_id  out  32  ID word from the last check.
- captured_ts  out  32  timestamp word from the last check.

Behaviour:
- Reset values:
  - FSM state CHK_ID; busy=1; done=0; id_ok=0; ts_ok=0.
  - captured_id=0; captured_ts=0; cpu_readdata=0; cpu_waitrequest=1.
  - slv_read=0; slv_address=0; cnt=0.
- FSM states: IDLE, CHK_ID, CHK_TS, CPU_RD, CPU_ACK.
- Read states (CHK_ID, CHK_TS, CPU_RD):
  - slv_read=1 and slv_address held constant for the whole state.
  - 3-bit cnt increments from 0. When cnt==READ_LATENCY, slv_readdata is captured, cnt clears and the state advances.
  - Each read state lasts READ_LATENCY+1 cycles.
- CHK_ID:
  - slv_address=0.
  - On capture: captured_id<=slv_readdata, id_ok<=(slv_readdata==EXPECTED_ID); go to CHK_TS.
- CHK_TS:
  - slv_address=1.
  - On capture: captured_ts<=slv_readdata, ts_ok<=(slv_readdata==EXPECTED_TIMESTAMP), done<=1; go to IDLE.
- A full check takes 2*(READ_LATENCY+1) cycles.
- busy=1 exactly in CHK_ID and CHK_TS (decoded from state).
- IDLE:
  - slv_read=0.
  - If start=1, go to CHK_ID. On entry, id_ok, ts_ok and done stay at their old values until overwritten by the capture.
  - Else if cpu_read=1, go to CPU_RD.
  - If start and cpu_read are high in the same cycle, the check wins and the CPU stays stalled.
- CPU_RD:
  - slv_address=cpu_address, sampled on entry and held.
  - On capture: cpu_readdata<=slv_readdata; go to CPU_ACK.
- CPU_ACK:
  - cpu_waitrequest=0 for exactly one cycle, then IDLE.
  - cpu_waitrequest=1 in every other state, including when cpu_read is low.
- A CPU read issued during a check stalls (waitrequest=1) until the check ends, then is served via IDLE->CPU_RD.
- start during CHK_ID, CHK_TS, CPU_RD or CPU_ACK is ignored and not queued.
- cpu_readdata holds its last value outside CPU_ACK.
- Asserting reset_n low mid-operation:
  - forces all outputs to their reset values immediately;
  - abandons any in-flight CPU read, which gets no ack;
  - on release, a fresh check starts.

Test Plan:
- Reset release with slave returning 0 / 1361531825, READ_LATENCY=0 -> slv_read high 2 cycles (address 0 then 1); busy falls on cycle 3; done=1, id_ok=1, ts_ok=1; captured_ts=1361531825.
- Slave returns 32'h00000005 at address 0 -> id_ok=0, ts_ok=1, done=1, captured_id=5.
- READ_LATENCY=3, slave data valid only from the 4th read cycle -> busy for 8 cycles; correct captures; slv_address stable 4 cycles per word.
- After check, CPU read address 1 with READ_LATENCY=0 -> waitrequest low exactly one cycle, two cycles after cpu_read rises; cpu_readdata=1361531825.
- start and cpu_read in the same IDLE cycle -> check runs first; CPU ack arrives after busy falls; start pulsed mid-check produces no second check.
- reset_n asserted during CHK_TS -> done=0, busy=1 immediately; after release, a full check repeats and completes with correct flags.
